// File: rtl/max_pool_stream.sv
// Streaming K x K / stride-K max-pool over CH parallel lanes, one pixel per beat in raster order.
// Define MAXPOOL_SIGNED_EN to compare samples as two's-complement; otherwise they compare unsigned.
module max_pool_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int CH         = 4,
  parameter int InputH     = 26,
  parameter int InputW     = 26,
  parameter int K          = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CH*DATA_WIDTH-1:0] pixIn,
  input  logic                     pixInValid,
  output logic                     pixInReady,
  output logic [CH*DATA_WIDTH-1:0] poolOut,
  output logic                     poolOutValid,
  input  logic                     poolOutReady,
  output logic                     poolOutLast
);

  localparam int OutH = InputH / K;
  localparam int OutW = InputW / K;
  localparam int ColW = $clog2(InputW + 1);
  localparam int RowW = $clog2(InputH + 1);
  localparam int KW   = $clog2(K);
  localparam int OxW  = (OutW > 1) ? $clog2(OutW) : 1;
  localparam int OyW  = (OutH > 1) ? $clog2(OutH) : 1;

  localparam logic [ColW-1:0] ColLast  = ColW'(InputW - 1);
  localparam logic [ColW-1:0] ColLimit = ColW'(OutW * K);
  localparam logic [RowW-1:0] RowLast  = RowW'(InputH - 1);
  localparam logic [RowW-1:0] RowLimit = RowW'(OutH * K);
  localparam logic [KW-1:0]   KLast    = KW'(K - 1);
  localparam logic [OxW-1:0]  OxLast   = OxW'(OutW - 1);
  localparam logic [OyW-1:0]  OyLast   = OyW'(OutH - 1);

  logic [ColW-1:0] col;
  logic [RowW-1:0] row;
  logic [KW-1:0]   kc, kr;
  logic [OxW-1:0]  ox;
  logic [OyW-1:0]  oy;

  logic [CH*DATA_WIDTH-1:0] rowMax [OutW];
  logic [CH*DATA_WIDTH-1:0] rowMaxRd;
  logic [CH*DATA_WIDTH-1:0] mergedMax;

  logic xfer, inWindow, windowStart, windowDone;

  assign pixInReady  = !poolOutValid || poolOutReady;
  assign xfer        = pixInValid && pixInReady;
  assign inWindow    = (col < ColLimit) && (row < RowLimit);
  assign windowStart = (kc == '0) && (kr == '0);
  assign windowDone  = (kc == KLast) && (kr == KLast);
  assign rowMaxRd    = rowMax[ox];

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : gLane
      logic [DATA_WIDTH-1:0] held, incoming;
      assign held     = rowMaxRd[gi*DATA_WIDTH +: DATA_WIDTH];
      assign incoming = pixIn[gi*DATA_WIDTH +: DATA_WIDTH];
`ifdef MAXPOOL_SIGNED_EN
      assign mergedMax[gi*DATA_WIDTH +: DATA_WIDTH] =
        ($signed(held) > $signed(incoming)) ? held : incoming;
`else
      assign mergedMax[gi*DATA_WIDTH +: DATA_WIDTH] = (held > incoming) ? held : incoming;
`endif
    end
  endgenerate

  // Partial maxima need no reset: the first pixel of every window overwrites its slot.
  always_ff @(posedge clk) begin
    if (xfer && inWindow) begin
      rowMax[ox] <= windowStart ? pixIn : mergedMax;
    end
  end

  // ox/oy saturate in the remainder band, where inWindow masks them anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      col <= '0;
      row <= '0;
      kc  <= '0;
      kr  <= '0;
      ox  <= '0;
      oy  <= '0;
    end else if (xfer) begin
      if (col == ColLast) begin
        col <= '0;
        kc  <= '0;
        ox  <= '0;
        if (row == RowLast) begin
          row <= '0;
          kr  <= '0;
          oy  <= '0;
        end else begin
          row <= row + 1'b1;
          if (kr == KLast) begin
            kr <= '0;
            if (oy != OyLast) oy <= oy + 1'b1;
          end else begin
            kr <= kr + 1'b1;
          end
        end
      end else begin
        col <= col + 1'b1;
        if (kc == KLast) begin
          kc <= '0;
          if (ox != OxLast) ox <= ox + 1'b1;
        end else begin
          kc <= kc + 1'b1;
        end
      end
    end
  end

  // A completing window in the same cycle as a consume reloads and keeps valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      poolOut      <= '0;
      poolOutValid <= 1'b0;
      poolOutLast  <= 1'b0;
    end else begin
      if (poolOutValid && poolOutReady) poolOutValid <= 1'b0;
      if (xfer && inWindow && windowDone) begin
        poolOut      <= mergedMax;
        poolOutValid <= 1'b1;
        poolOutLast  <= (oy == OyLast) && (ox == OxLast);
      end
    end
  end

endmodule

// File: doc/max_pool_stream.md
# max_pool_stream

Streaming, multi-channel K×K max-pool with stride K, replacing the fully combinational whole-map poolers. It accepts one pixel per cycle in raster order, carrying CH channels side by side, over a valid/ready handshake. It keeps one partial-max row in registers and emits one pooled pixel per completed window. It sits between a convolution output stream and the next layer's input stream.

## Interface
- DATA_WIDTH, 16: bits per channel sample
- CH, 4: channels per beat, processed in parallel lanes
- InputH, 26: input rows per frame
- InputW, 26: input columns per frame
- K, 2: kernel size and stride; must satisfy 2 ≤ K ≤ min(InputH, InputW)
- Derived: OutH = InputH/K, OutW = InputW/K (integer division)

Ports:
- clk, input, 1: single clock; all logic on the rising edge
- reset, input, 1: synchronous, active-high
- pixIn, input, CH*DATA_WIDTH: channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- pixInValid, input, 1: pixIn holds a valid pixel
- pixInReady, output, 1: block can accept a pixel this cycle
- poolOut, output, CH*DATA_WIDTH: pooled pixel, same lane packing as pixIn
- poolOutValid, output, 1: poolOut holds a valid pooled pixel
- poolOutReady, input, 1: downstream accepts poolOut
- poolOutLast, output, 1: qualifies the final pooled pixel of a frame

## Operation
- Transfer occurs when pixInValid && pixInReady. Counters advance only on a transfer.
- Position counters: col 0..InputW-1 and row 0..InputH-1. Derived values: kc = col mod K, kr = row mod K, ox = col/K, oy = row/K.
- Partial buffer rowMax[OutW][CH]:
  - At kr==0 && kc==0, write the pixel.
  - Otherwise, write max(rowMax[ox], pixel) lane-wise.
- Window complete at kr==K-1 && kc==K-1:
  - max(rowMax[ox], pixel) loads the output register and sets poolOutValid.
  - poolOutLast = (oy==OutH-1 && ox==OutW-1).
- Remainder pixels (col ≥ OutW*K or row ≥ OutH*K) are accepted and ignored. They do not touch rowMax and produce no output.
- End of frame: after the transfer at row==InputH-1, col==InputW-1, both counters wrap to 0. The next transfer starts a new frame with no idle cycle.
- Output register holds poolOut, poolOutValid and poolOutLast stable until poolOutValid && poolOutReady. Consumption clears poolOutValid unless a new window completes in the same cycle.
- Comparison is lane-independent. Sign handling is set by the macro under Configuration.

## Timing
- Reset values:
  - poolOutValid = 0, poolOut = 0, poolOutLast = 0
  - row = 0, col = 0
  - rowMax is not reset; it is always written before it is read.
- pixInReady = !poolOutValid || poolOutReady. This is combinational; the block never drops or overwrites an unconsumed output.
- Latency: poolOutValid is high the cycle after the transfer of the window's last pixel.
- Throughput: 1 pixel/cycle while poolOutReady is held high. Output rate is one beat per K² in-window inputs.
- Simultaneous output consumption and window completion: the new result loads and poolOutValid stays 1.
- Reset asserted mid-frame: the partial frame is discarded and any pending output is dropped. The first transfer after reset is pixel (0,0).
- pixIn is not sampled when pixInValid is 0. Bubbles anywhere in a frame do not affect results.

## Configuration
- MAXPOOL_SIGNED_EN:
  - Defined: samples are compared as two's-complement signed values.
  - Undefined: samples are compared as unsigned.
- The macro affects only the comparator. Ports, latency and handshake are identical in both builds.

## Test plan
- Ramp, K=2, CH=2, InputH=InputW=4: lane0 = row*4+col, lane1 = 15-lane0, no backpressure.
  - Outputs lane0: 5, 7, 13, 15. Outputs lane1: 10, 8, 2, 0.
  - poolOutLast is set on the 4th output only. Each output arrives 1 cycle after its window's final pixel.
- Same frame with poolOutReady toggling 1-of-3 cycles:
  - Identical output sequence.
  - pixInReady low exactly while an output is pending and poolOutReady is low.
  - No output is lost or duplicated.
- Signed data, lane values {-3, -1, -7, -2} in one 2×2 window:
  - With MAXPOOL_SIGNED_EN: output -1 (0xFFFF).
  - Without the macro: output 0xFFFF, as the unsigned max.
  - Repeat with {-3, 2, -7, 1}: the signed build gives 2 and the unsigned build gives 0xFFFD.
- Remainder, InputH=InputW=5, K=2, pixel value = row*5+col:
  - 4 outputs: 6, 8, 16, 18.
  - Row 4 and column 4 are accepted without any output.
  - The next frame starts cleanly.
- Reset asserted after 6 pixels of a 4×4 frame, then a full new frame: only the new frame's 4 correct outputs appear.
- Two back-to-back frames with no gap: 8 outputs, with poolOutLast on outputs 4 and 8.
